// File: rtl/pim_pkg.sv
// Shared types and helpers for the time-multiplexed PIM accumulator engine.
package pim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Largest tile geometry the crossbar macro can be built with.
    localparam int MAX_SIZE_ROW = 1024;
    localparam int MAX_SIZE_COL = 64;

    function automatic int num_tiles(input int input_size, input int tile_rows);
        return input_size / tile_rows;
    endfunction

    function automatic bit params_ok(input int input_size, input int tile_rows,
                                     input int depth, input int adc_p, input int acc_w);
        return (tile_rows > 0) && (tile_rows <= MAX_SIZE_ROW) &&
               (input_size >= tile_rows) && ((input_size % tile_rows) == 0) &&
               ((1 << depth) <= MAX_SIZE_COL) &&
               (tile_rows >= adc_p) && (acc_w >= adc_p);
    endfunction

endpackage

// File: rtl/bram_pim.sv
// Behavioural stand-in for the crossbar macro: the ADC sample is the low ADC_P
// bits of the presented row vector; the column address does not change it.
module bram_pim #(
    parameter int ROWS  = 192,
    parameter int DEPTH = 5,
    parameter int ADC_P = 8
) (
    input  logic             clk,
    input  logic [ROWS-1:0]  data,
    input  logic [DEPTH-1:0] addr,
    input  logic             we,
    output logic [ADC_P-1:0] out
);

    logic unused_inputs;

    assign out           = data[ADC_P-1:0];
    assign unused_inputs = ^{clk, we, addr, data};

endmodule

// File: rtl/pim_tile.sv
// One crossbar tile plus its ADC output register: a chunk issued in cycle t
// appears as sample/rsp_valid in cycle t+1.
module pim_tile #(
    parameter int TILE_ROWS = 192,
    parameter int DEPTH     = 5,
    parameter int ADC_P     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue,
    input  logic [TILE_ROWS-1:0] chunk,
    input  logic [DEPTH-1:0]     addr,
    output logic                 rsp_valid,
    output logic [ADC_P-1:0]     sample
);

    logic [ADC_P-1:0] adc_out;

    bram_pim #(
        .ROWS (TILE_ROWS),
        .DEPTH(DEPTH),
        .ADC_P(ADC_P)
    ) u_bram (
        .clk (clk),
        .data(chunk),
        .addr(addr),
        .we  (issue),
        .out (adc_out)
    );

    // Clearing rsp_valid on reset drops any response still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            sample    <= '0;
        end else begin
            rsp_valid <= issue;
            if (issue) sample <= adc_out;
        end
    end

endmodule

// File: rtl/pim_seq_accum.sv
// Matrix-vector engine that streams an INPUT_SIZE vector through one shared
// crossbar tile and accumulates the ADC samples with optional saturation.
module pim_seq_accum
    import pim_pkg::*;
#(
    parameter int INPUT_SIZE = 384,
    parameter int TILE_ROWS  = 192,
    parameter int DEPTH      = 5,
    parameter int ADC_P      = 8,
    parameter int ACC_W      = 16,
    parameter bit SIGNED     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INPUT_SIZE-1:0] Input_feature,
    input  logic [DEPTH-1:0]      Address,
    input  logic                  sat_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      Output,
    output logic                  overflow,
    output logic                  busy,
    output state_t                dbg_state
);

    localparam int NUM_TILES = num_tiles(INPUT_SIZE, TILE_ROWS);
    localparam int CNT_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam logic [CNT_W-1:0] LAST_TILE = CNT_W'(NUM_TILES - 1);
    localparam logic [ACC_W-1:0] POS_LIM =
        SIGNED ? {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] NEG_LIM =
        SIGNED ? {1'b1, {(ACC_W-1){1'b0}}} : {ACC_W{1'b0}};

    if (!params_ok(INPUT_SIZE, TILE_ROWS, DEPTH, ADC_P, ACC_W)) begin : g_param_check
        $error("pim_seq_accum: unsupported parameter set");
    end

    // Handshakes: a request moves when in_valid & in_ready at a rising edge; a
    // result moves when out_valid & out_ready. Neither valid waits on ready.
    state_t                  state;
    logic [INPUT_SIZE-1:0]   feat_q;
    logic [DEPTH-1:0]        addr_q;
    logic                    sat_q;
    logic [CNT_W-1:0]        tile_cnt;
    logic [ACC_W-1:0]        acc;

    logic                    issue;
    logic [TILE_ROWS-1:0]    chunk;
    logic                    rsp_valid;
    logic [ADC_P-1:0]        sample;

    logic [ACC_W:0]          acc_x;
    logic [ACC_W:0]          smp_x;
    logic [ACC_W:0]          sum;
    logic                    out_of_range;
    logic [ACC_W-1:0]        acc_next;

    assign issue     = (state == ISSUE) && en;
    assign chunk     = feat_q[int'(tile_cnt) * TILE_ROWS +: TILE_ROWS];
    assign Output    = acc;
    assign dbg_state = state;

    pim_tile #(
        .TILE_ROWS(TILE_ROWS),
        .DEPTH    (DEPTH),
        .ADC_P    (ADC_P)
    ) u_tile (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue    (issue),
        .chunk    (chunk),
        .addr     (addr_q),
        .rsp_valid(rsp_valid),
        .sample   (sample)
    );

    // One spare MSB lets the range check read the true sum before clamping.
    always_comb begin
        acc_x = SIGNED ? {acc[ACC_W-1], acc} : {1'b0, acc};
        smp_x = SIGNED ? {{(ACC_W+1-ADC_P){sample[ADC_P-1]}}, sample}
                       : {{(ACC_W+1-ADC_P){1'b0}}, sample};
        sum   = acc_x + smp_x;
        out_of_range = SIGNED ? (sum[ACC_W] != sum[ACC_W-1]) : sum[ACC_W];
        if (out_of_range && sat_q)
            acc_next = (SIGNED && sum[ACC_W]) ? NEG_LIM : POS_LIM;
        else
            acc_next = sum[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            feat_q    <= '0;
            addr_q    <= '0;
            sat_q     <= 1'b0;
            tile_cnt  <= '0;
            acc       <= '0;
            overflow  <= 1'b0;
        end else begin
            // Samples land whatever en is doing; IDLE's clear below wins.
            if (rsp_valid) begin
                acc      <= acc_next;
                overflow <= overflow | out_of_range;
            end
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        feat_q   <= Input_feature;
                        addr_q   <= Address;
                        sat_q    <= sat_mode;
                        tile_cnt <= '0;
                        acc      <= '0;
                        overflow <= 1'b0;
                        state    <= ISSUE;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (en) begin
                        tile_cnt <= tile_cnt + CNT_W'(1);
                        if (tile_cnt == LAST_TILE) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (en) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pim_seq_accum.sv
// Bench for pim_seq_accum: three configurations (unsigned/8, signed/8,
// unsigned/16 with four tiles) checked against a transaction-level model.
module tb_pim_seq_accum;
    import pim_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sat_mode;
    logic        out_ready;
    logic [4:0]  addr;
    logic [63:0] feat;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        overflow  [3];
    logic        busy      [3];
    logic [7:0]  dout0;
    logic [7:0]  dout1;
    logic [15:0] dout2;
    state_t      dbg0;
    state_t      dbg1;
    state_t      dbg2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rand_on;

    // Model state per DUT: transaction pending, en-high cycles since accept.
    bit          pend    [3];
    int          ecnt    [3];
    logic [15:0] exp_res [3];
    bit          exp_ovf [3];

    pim_seq_accum #(.INPUT_SIZE(32), .TILE_ROWS(16), .DEPTH(5), .ADC_P(8), .ACC_W(8), .SIGNED(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .Input_feature(feat[31:0]), .Address(addr), .sat_mode(sat_mode), .out_valid(out_valid[0]),
        .out_ready(out_ready), .Output(dout0), .overflow(overflow[0]), .busy(busy[0]), .dbg_state(dbg0));

    pim_seq_accum #(.INPUT_SIZE(32), .TILE_ROWS(16), .DEPTH(5), .ADC_P(8), .ACC_W(8), .SIGNED(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .Input_feature(feat[31:0]), .Address(addr), .sat_mode(sat_mode), .out_valid(out_valid[1]),
        .out_ready(out_ready), .Output(dout1), .overflow(overflow[1]), .busy(busy[1]), .dbg_state(dbg1));

    pim_seq_accum #(.INPUT_SIZE(64), .TILE_ROWS(16), .DEPTH(5), .ADC_P(8), .ACC_W(16), .SIGNED(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .Input_feature(feat), .Address(addr), .sat_mode(sat_mode), .out_valid(out_valid[2]),
        .out_ready(out_ready), .Output(dout2), .overflow(overflow[2]), .busy(busy[2]), .dbg_state(dbg2));

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // ---------------- reference model ----------------
    function automatic int nt_of(input int d);
        return (d == 2) ? 4 : 2;
    endfunction

    function automatic int aw_of(input int d);
        return (d == 2) ? 16 : 8;
    endfunction

    function automatic bit sg_of(input int d);
        return (d == 1);
    endfunction

    function automatic logic [15:0] get_out(input int d);
        if (d == 0) return {8'd0, dout0};
        if (d == 1) return {8'd0, dout1};
        return dout2;
    endfunction

    function automatic state_t get_dbg(input int d);
        if (d == 0) return dbg0;
        if (d == 1) return dbg1;
        return dbg2;
    endfunction

    // Sum the chunk LSB bytes one by one, applying range, saturation or wrap.
    function automatic void model_txn(input logic [63:0] f, input int d, input bit sat,
                                      output logic [15:0] res, output bit ovf);
        longint acc, s, lo, hi, m;
        logic [7:0] b;
        m = longint'(1) << aw_of(d);
        if (sg_of(d)) begin
            lo = -(m / 2);
            hi = m / 2 - 1;
        end else begin
            lo = 0;
            hi = m - 1;
        end
        acc = 0;
        ovf = 1'b0;
        for (int k = 0; k < nt_of(d); k++) begin
            b = f[k*16 +: 8];
            s = sg_of(d) ? longint'($signed(b)) : longint'(b);
            acc = acc + s;
            if (acc < lo || acc > hi) begin
                ovf = 1'b1;
                if (sat) begin
                    acc = (acc < lo) ? lo : hi;
                end else begin
                    acc = acc % m;
                    if (acc < 0) acc = acc + m;
                    if (sg_of(d) && acc > hi) acc = acc - m;
                end
            end
        end
        res = 16'(acc & (m - 1));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                pend[d] = 1'b0;
                ecnt[d] = 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (!pend[d]) begin
                    if (in_valid[d]) begin
                        pend[d] = 1'b1;
                        ecnt[d] = 0;
                        model_txn(feat, d, sat_mode, exp_res[d], exp_ovf[d]);
                    end
                end else if (ecnt[d] < nt_of(d) + 1) begin
                    if (en) ecnt[d] = ecnt[d] + 1;
                end else if (out_ready) begin
                    pend[d] = 1'b0;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [7:0] c0, input logic [7:0] c1,
                                       input logic [7:0] c2, input logic [7:0] c3);
        logic [63:0] f;
        f = {$urandom, $urandom};
        f[7:0]   = c0;
        f[23:16] = c1;
        f[39:32] = c2;
        f[55:48] = c3;
        return f;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input int d, input logic [63:0] f, input bit sat, output int acc_c);
        @(posedge clk);
        #1;
        feat        = f;
        sat_mode    = sat;
        addr        = 5'($urandom_range(0, 31));
        in_valid[d] = 1'b1;
        acc_c       = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready[d]) begin
                acc_c = cyc;
                break;
            end
        end
        if (acc_c < 0) check($sformatf("d%0d accept timeout", d), 0, 1);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        feat        = {$urandom, $urandom};
        sat_mode    = ~sat_mode;
    endtask

    task automatic wait_out(input int d, input int acc_c, output int lat,
                            output logic [15:0] res, output bit ovf);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        res  = '0;
        ovf  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid[d]) begin
                lat  = cyc - acc_c;
                res  = get_out(d);
                ovf  = overflow[d];
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check($sformatf("d%0d out_valid timeout", d), 0, 1);
    endtask

    task automatic run_one(input int d, input logic [63:0] f, input bit sat,
                           input logic [15:0] want, input bit want_ovf, input string tag);
        int c, lat;
        logic [15:0] res;
        bit ovf;
        send(d, f, sat, c);
        wait_out(d, c, lat, res, ovf);
        check({tag, " latency"}, lat, nt_of(d) + 2);
        check({tag, " Output"}, res, want);
        check({tag, " overflow"}, ovf, want_ovf);
    endtask

    // ---------------- stimulus, per-cycle compare, report ----------------
    initial begin
        int c1, c2, lat;
        logic [15:0] res;
        bit ovf;

        rst_n     = 1'b0;
        en        = 1'b1;
        out_ready = 1'b1;
        sat_mode  = 1'b0;
        addr      = '0;
        feat      = '0;
        for (int d = 0; d < 3; d++) in_valid[d] = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    for (int d = 0; d < 3; d++) begin
                        check($sformatf("d%0d in_ready", d), in_ready[d], !pend[d]);
                        check($sformatf("d%0d busy", d), busy[d], pend[d]);
                        check($sformatf("d%0d out_valid", d), out_valid[d],
                              pend[d] && (ecnt[d] == nt_of(d) + 1));
                        if (pend[d] && (ecnt[d] == nt_of(d) + 1)) begin
                            check($sformatf("d%0d Output", d), get_out(d), exp_res[d]);
                            check($sformatf("d%0d overflow", d), overflow[d], exp_ovf[d]);
                        end
                    end
                end
            end
        join_none

        #12;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d reset in_ready", d), in_ready[d], 1);
            check($sformatf("d%0d reset out_valid", d), out_valid[d], 0);
            check($sformatf("d%0d reset busy", d), busy[d], 0);
            check($sformatf("d%0d reset overflow", d), overflow[d], 0);
            check($sformatf("d%0d reset Output", d), get_out(d), 0);
            check($sformatf("d%0d reset state", d), 32'(get_dbg(d)), 32'(IDLE));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Hand-computed results for the basic arithmetic cases.
        run_one(0, mk(8'd100, 8'd50, 8'd0, 8'd0),  1'b1, 16'd150, 1'b0, "u8 100+50 sat");
        run_one(0, mk(8'd200, 8'd100, 8'd0, 8'd0), 1'b1, 16'd255, 1'b1, "u8 200+100 sat");
        run_one(0, mk(8'd200, 8'd100, 8'd0, 8'd0), 1'b0, 16'd44,  1'b1, "u8 200+100 wrap");
        run_one(1, mk(8'h9C, 8'h9C, 8'd0, 8'd0),   1'b1, 16'h80,  1'b1, "s8 -100-100 sat");
        run_one(1, mk(8'h9C, 8'h9C, 8'd0, 8'd0),   1'b0, 16'd56,  1'b1, "s8 -100-100 wrap");

        // Three en-low cycles mid-issue, then a consumer that stalls five cycles.
        send(0, mk(8'd100, 8'd50, 8'd0, 8'd0), 1'b1, c1);
        @(posedge clk);
        #1;
        en = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1;
        wait_out(0, c1, lat, res, ovf);
        check("stall latency", lat, 7);
        check("stall Output", res, 150);
        repeat (5) begin
            @(negedge clk);
            check("hold Output", get_out(0), 150);
            check("hold overflow", overflow[0], 0);
            check("hold in_ready", in_ready[0], 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Reset while draining, then a clean transaction afterwards.
        send(0, mk(8'd7, 8'd9, 8'd0, 8'd0), 1'b0, c1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre-reset state", 32'(dbg0), 32'(DRAIN));
        rst_n = 1'b0;
        #1;
        check("mid reset Output", get_out(0), 0);
        check("mid reset out_valid", out_valid[0], 0);
        check("mid reset overflow", overflow[0], 0);
        check("mid reset busy", busy[0], 0);
        check("mid reset in_ready", in_ready[0], 1);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no stale out_valid", out_valid[0], 0);
        end
        run_one(0, mk(8'd1, 8'd2, 8'd0, 8'd0), 1'b0, 16'd3, 1'b0, "post-reset 1+2");

        // Back-to-back requests: initiation interval NUM_TILES+3.
        send(0, mk(8'd10, 8'd20, 8'd0, 8'd0), 1'b0, c1);
        send(0, mk(8'd30, 8'd40, 8'd0, 8'd0), 1'b0, c2);
        check("u8 initiation interval", c2 - c1, 5);
        wait_out(0, c2, lat, res, ovf);
        check("u8 b2b Output", res, 70);
        send(2, mk(8'd255, 8'd255, 8'd255, 8'd255), 1'b0, c1);
        send(2, mk(8'd255, 8'd255, 8'd255, 8'd255), 1'b1, c2);
        check("u16 initiation interval", c2 - c1, 7);
        wait_out(2, c2, lat, res, ovf);
        check("u16 latency", lat, 6);
        check("u16 4x255 Output", res, 1020);
        check("u16 4x255 overflow", ovf, 0);

        // Randomised traffic with random en and out_ready stalls.
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    en        = ($urandom_range(0, 3) != 0);
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                en        = 1'b1;
                out_ready = 1'b1;
            end
            begin
                for (int n = 0; n < 60; n++) begin
                    send($urandom_range(0, 2), {$urandom, $urandom}, 1'($urandom_range(0, 1)), c1);
                end
                for (int i = 0; i < 1000 && (pend[0] || pend[1] || pend[2]); i++) @(posedge clk);
                check("random drain", {29'd0, pend[0], pend[1], pend[2]}, 0);
                rand_on = 1'b0;
            end
        join
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pim_seq_accum.md
# pim_seq_accum

Time-multiplexed PIM matrix-vector engine: one crossbar tile of TILE_ROWS rows serves an INPUT_SIZE-wide input vector by issuing the vector tile-by-tile. It accumulates the ADC samples into a wider, optionally saturating accumulator. Results are returned over a valid/ready handshake. It replaces the fully unrolled row-split adder tree with one shared tile, one adder, and an FSM, so layer width no longer costs crossbar area.

## Interface
- INPUT_SIZE, 384: input vector width in bits; must be an integer multiple of TILE_ROWS.
- TILE_ROWS, 192: crossbar rows per tile issue; NUM_TILES = INPUT_SIZE/TILE_ROWS, must be ≥1.
- DEPTH, 5: crossbar column address width.
- ADC_P, 8: ADC sample width.
- ACC_W, 16: accumulator and output width; must be ≥ ADC_P.
- SIGNED, 1: 1 = ADC samples are two's complement (sign-extended); 0 = unsigned (zero-extended).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  engine enable; 0 stalls tile issue.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- Input_feature  in  INPUT_SIZE  input vector, captured at acceptance.
- Address  in  DEPTH  crossbar column, captured at acceptance.
- sat_mode  in  1  1 = saturate, 0 = wrap; captured at acceptance.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- Output  out  ACC_W  accumulated result.
- overflow  out  1  range exceeded at least once during this transaction.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On handshake: capture vector, Address and sat_mode; clear acc, overflow and tile_cnt; go to ISSUE.
- ISSUE:
  - Each cycle with en=1, present chunk tile_cnt (chunk k = Input_feature[k*TILE_ROWS +: TILE_ROWS], chunk 0 = LSBs) with the captured Address.
  - Increment tile_cnt each such cycle.
  - After the cycle that issues chunk NUM_TILES-1, go to DRAIN.
  - With en=0: no issue, tile_cnt holds.
- DRAIN: wait for the last sample to be accumulated. With en=0, hold in DRAIN.
- DONE:
  - out_valid=1; Output and overflow are stable.
  - On out_ready, go to IDLE.
- Accumulate: a sample returned by the tile is always added, regardless of en.
  - Extension: sign- or zero-extend the sample per SIGNED, then compute sum = acc + sample at ACC_W+1 bits.
  - Out of range: SIGNED=1 range is [-2^(ACC_W-1), 2^(ACC_W-1)-1]; SIGNED=0 range is [0, 2^ACC_W-1]. An out-of-range sum sets overflow (sticky).
  - Saturation: if sat_mode=1, clamp to the range limit; otherwise keep the low ACC_W bits (wrap).
- Output = acc. It is only meaningful while out_valid=1.
- No request overlap: in_ready=0 in ISSUE, DRAIN and DONE.

## Timing
- Reset (asserted, and immediately after):
  - state=IDLE, so in_ready=1.
  - out_valid=0, Output=0, overflow=0, busy=0.
  - tile_cnt=0; the pending tile response is discarded.
- Tile read latency is exactly 1 cycle. A chunk issued in cycle t is accumulated at the end of cycle t+1.
- Latency with en held at 1: handshake in cycle 0 → out_valid in cycle NUM_TILES+2.
  - Example: NUM_TILES=2 → cycle 4.
- Each en=0 cycle in ISSUE or DRAIN adds one cycle of latency.
- Minimum initiation interval is NUM_TILES+3 cycles. DONE→IDLE costs one cycle; the next acceptance is at the earliest in the cycle after the out handshake.
- out_valid=1 with out_ready=0: Output and overflow hold indefinitely.
- Reset mid-transaction: the transaction is abandoned and no out_valid is produced. The first post-reset request yields only its own result.
- Changes to in_valid, Input_feature or sat_mode after acceptance have no effect on the transaction.

## Structure
- Shared package pim_pkg holds:
  - the state enum (IDLE/ISSUE/DRAIN/DONE);
  - the MAX_SIZE_ROW / MAX_SIZE_COL constants;
  - a num_tiles(INPUT_SIZE, TILE_ROWS) function;
  - elaboration checks (divisibility, ACC_W ≥ ADC_P).
- One sub-module, pim_tile:
  - wraps bram_pim (data/addr/we/out/clk) for one TILE_ROWS × 2^DEPTH tile;
  - registers the ADC sample plus a rsp_valid bit (1-cycle latency);
  - clears rsp_valid on reset.
- The top level holds the FSM, capture registers, chunk mux and saturating accumulator.

## Test plan
The bench's bram_pim model returns the registered data[ADC_P-1:0] of the presented chunk. Unless stated otherwise: NUM_TILES=2, ADC_P=8, ACC_W=8.
- SIGNED=0, sat_mode=1, chunk LSBs 100 and 50 → Output=150, overflow=0, out_valid in cycle 4.
- SIGNED=0, chunk LSBs 200 and 100:
  - sat_mode=1 → Output=255, overflow=1.
  - sat_mode=0 → Output=44, overflow=1.
- SIGNED=1, chunk LSBs -100 and -100:
  - sat_mode=1 → Output=-128, overflow=1.
  - sat_mode=0 → Output=56, overflow=1.
- en low for 3 cycles mid-ISSUE → the same Output as the unstalled run, out_valid 3 cycles later. out_ready held low 5 cycles → Output stable, in_ready=0 throughout.
- rst asserted in DRAIN → all outputs 0 at once. The next request (chunks 1 and 2) → Output=3 with no stale residue.
- Back-to-back requests with out_ready=1 → second acceptance exactly NUM_TILES+3 cycles after the first. Repeat with NUM_TILES=4, ACC_W=16 and chunks 255×4 → Output=1020.
